// File: rtl/avr_pkg.sv
// avr_pkg: opcode enum, SREG bit indices and decode patterns shared by the AVR core
package avr_pkg;
    typedef enum logic [3:0] {
        OP_ADD, OP_ADC, OP_SUB, OP_SUBI, OP_AND, OP_EOR, OP_OR,
        OP_MOV, OP_LDI, OP_INC, OP_DEC, OP_NOP, OP_ILL
    } op_t;
    localparam int SREG_C = 0;
    localparam int SREG_Z = 1;
    localparam int SREG_N = 2;
    localparam int SREG_V = 3;
    localparam int SREG_S = 4;
    localparam int SREG_H = 5;
    localparam logic [15:0] M_RR   = 16'hFC00;
    localparam logic [15:0] M_IMM  = 16'hF000;
    localparam logic [15:0] M_ONE  = 16'hFE0F;
    localparam logic [15:0] P_ADD  = 16'h0C00;
    localparam logic [15:0] P_ADC  = 16'h1C00;
    localparam logic [15:0] P_SUB  = 16'h1800;
    localparam logic [15:0] P_AND  = 16'h2000;
    localparam logic [15:0] P_EOR  = 16'h2400;
    localparam logic [15:0] P_OR   = 16'h2800;
    localparam logic [15:0] P_MOV  = 16'h2C00;
    localparam logic [15:0] P_LDI  = 16'hE000;
    localparam logic [15:0] P_SUBI = 16'h5000;
    localparam logic [15:0] P_INC  = 16'h9403;
    localparam logic [15:0] P_DEC  = 16'h940A;
    function automatic op_t decode(input logic [15:0] i);
        return i == 16'h0000        ? OP_NOP  :
               (i & M_RR)  == P_ADD ? OP_ADD  :
               (i & M_RR)  == P_ADC ? OP_ADC  :
               (i & M_RR)  == P_SUB ? OP_SUB  :
               (i & M_RR)  == P_AND ? OP_AND  :
               (i & M_RR)  == P_EOR ? OP_EOR  :
               (i & M_RR)  == P_OR  ? OP_OR   :
               (i & M_RR)  == P_MOV ? OP_MOV  :
               (i & M_IMM) == P_LDI ? OP_LDI  :
               (i & M_IMM) == P_SUBI ? OP_SUBI :
               (i & M_ONE) == P_INC ? OP_INC  :
               (i & M_ONE) == P_DEC ? OP_DEC  : OP_ILL;
    endfunction
endpackage

// File: rtl/avr_alu.sv
// avr_alu: combinational AVR ALU producing the result and the next {H,S,V,N,Z,C} flags
module avr_alu
    import avr_pkg::*;
(
    input  logic       [3:0] op,
    input  logic       [7:0] a,
    input  logic       [7:0] b,
    input  logic             cin,
    input  logic             hin,
    output logic       [7:0] result,
    output logic       [7:0] flags
);
    logic       c_add;
    logic [8:0] sum;
    logic [8:0] dif;
    logic       c;
    logic       h;
    logic       v;
    always_comb begin
        c_add  = (op_t'(op) == OP_ADC) & cin;
        sum    = {1'b0, a} + {1'b0, b} + {8'd0, c_add};
        dif    = {1'b0, a} - {1'b0, b};
        result = a;
        c      = cin;
        h      = hin;
        v      = 1'b0;
        case (op_t'(op))
            OP_ADD, OP_ADC: begin
                result = sum[7:0];
                c      = sum[8];
                h      = (a[3] & b[3]) | (b[3] & ~sum[3]) | (~sum[3] & a[3]);
                v      = (a[7] == b[7]) && (sum[7] != a[7]);
            end
            OP_SUB, OP_SUBI: begin
                result = dif[7:0];
                c      = dif[8];
                h      = (~a[3] & b[3]) | (b[3] & dif[3]) | (dif[3] & ~a[3]);
                v      = (a[7] != b[7]) && (dif[7] != a[7]);
            end
            OP_AND: result = a & b;
            OP_EOR: result = a ^ b;
            OP_OR:  result = a | b;
            OP_MOV, OP_LDI: result = b;
            OP_INC: begin
                result = a + 8'd1;
                v      = result == 8'h80;
            end
            OP_DEC: begin
                result = a - 8'd1;
                v      = result == 8'h7F;
            end
            default: ;
        endcase
        flags = {2'b00, h, result[7] ^ v, v, result[7], result == 8'h00, c};
    end
endmodule

// File: rtl/avr_risc_core.sv
// avr_risc_core: single-cycle AVR-subset core executing a 16-bit instruction stream on a 32x8 register file
module avr_risc_core
    import avr_pkg::*;
#(
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [7:0]  wb_data,
    output logic [7:0]  sreg,
    output logic        illegal
);
    logic [7:0] regs [32];
    op_t        op;
    logic       imm_fmt;
    logic [4:0] dst;
    logic [4:0] src;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [7:0] flags;
    logic       writes;
    logic       sets_flags;
    always_comb begin
        op         = decode(instr);
        imm_fmt    = op == OP_LDI || op == OP_SUBI;
        dst        = imm_fmt ? {1'b1, instr[7:4]} : instr[8:4];
        src        = {instr[9], instr[3:0]};
        a          = regs[dst];
        b          = imm_fmt ? {instr[11:8], instr[3:0]} : regs[src];
        writes     = op != OP_NOP && op != OP_ILL;
        sets_flags = writes && op != OP_MOV && op != OP_LDI;
    end
    avr_alu u_alu (
        .op     (op),
        .a      (a),
        .b      (b),
        .cin    (sreg[SREG_C]),
        .hin    (sreg[SREG_H]),
        .result (res),
        .flags  (flags)
    );
    // Operands are read combinationally before the edge, so Rd==Rr uses the pre-write value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= RESET_VAL;
            sreg    <= 8'h00;
            wb_en   <= 1'b0;
            wb_addr <= 5'd0;
            wb_data <= 8'h00;
            illegal <= 1'b0;
        end else begin
            wb_en   <= 1'b0;
            illegal <= 1'b0;
            if (instr_valid) begin
                illegal <= op == OP_ILL;
                if (writes) begin
                    regs[dst] <= res;
                    wb_en     <= 1'b1;
                    wb_addr   <= dst;
                    wb_data   <= res;
                end
                if (sets_flags) sreg <= flags;
            end
        end
    end
endmodule

// File: tb/tb_avr_risc_core.sv
// tb_avr_risc_core: directed scoreboard bench comparing writeback/status outputs against hand-derived values
module tb_avr_risc_core;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [7:0]  wb_data;
    logic [7:0]  sreg;
    logic        illegal;
    typedef struct packed {
        logic       en;
        logic [4:0] addr;
        logic [7:0] data;
        logic [7:0] sr;
        logic       ill;
    } exp_t;
    exp_t sb[$];
    int   vectors = 0;
    int   errors = 0;
    avr_risc_core #(.RESET_VAL(8'h00)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr       (instr),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .sreg        (sreg),
        .illegal     (illegal)
    );
    always #5 clk = ~clk;
    task automatic step(input string tag, input logic r, input logic v, input logic [15:0] i,
                        input logic e_en, input logic [4:0] e_addr, input logic [7:0] e_data,
                        input logic [7:0] e_sr, input logic e_ill);
        exp_t got;
        exp_t e;
        @(negedge clk);
        reset       = r;
        instr_valid = v;
        instr       = i;
        sb.push_back('{e_en, e_addr, e_data, e_sr, e_ill});
        @(posedge clk);
        #1;
        got = '{wb_en, wb_addr, wb_data, sreg, illegal};
        vectors++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            assert (got === e) else begin
                errors++;
                $error("FAIL %s got en=%0b addr=%0d data=%02h sreg=%02h ill=%0b expected en=%0b addr=%0d data=%02h sreg=%02h ill=%0b",
                       tag, got.en, got.addr, got.data, got.sr, got.ill, e.en, e.addr, e.data, e.sr, e.ill);
            end
        end
    endtask
    initial begin
        step("reset_over_valid", 1, 1, 16'hE0FF, 0, 0, 8'h00, 8'h00, 0);
        step("reset_hold",       1, 0, 16'h0000, 0, 0, 8'h00, 8'h00, 0);
        step("reset_release",    0, 0, 16'h0000, 0, 0, 8'h00, 8'h00, 0);
        step("mov_r0_r31",       0, 1, 16'h2E0F, 1, 0, 8'h00, 8'h00, 0);
        step("ldi_r16",          0, 1, 16'hE00F, 1, 16, 8'h0F, 8'h00, 0);
        step("ldi_r17",          0, 1, 16'hE011, 1, 17, 8'h01, 8'h00, 0);
        step("add_half_carry",   0, 1, 16'h0F01, 1, 16, 8'h10, 8'h20, 0);
        step("ldi_r18",          0, 1, 16'hEF2F, 1, 18, 8'hFF, 8'h20, 0);
        step("inc_wrap",         0, 1, 16'h9523, 1, 18, 8'h00, 8'h22, 0);
        step("subi_borrow",      0, 1, 16'h5200, 1, 16, 8'hF0, 8'h15, 0);
        step("illegal",          0, 1, 16'hFFFF, 0, 16, 8'hF0, 8'h15, 1);
        step("idle",             0, 0, 16'hE0FF, 0, 16, 8'hF0, 8'h15, 0);
        step("mov_r1_r16",       0, 1, 16'h2E10, 1, 1, 8'hF0, 8'h15, 0);
        step("adc_same_reg",     0, 1, 16'h1F00, 1, 16, 8'hE1, 8'h15, 0);
        step("sub_r17_r16",      0, 1, 16'h1B10, 1, 17, 8'h20, 8'h01, 0);
        step("ldi_r19_7f",       0, 1, 16'hE73F, 1, 19, 8'h7F, 8'h01, 0);
        step("inc_overflow",     0, 1, 16'h9533, 1, 19, 8'h80, 8'h0D, 0);
        step("dec_overflow",     0, 1, 16'h953A, 1, 19, 8'h7F, 8'h19, 0);
        step("and",              0, 1, 16'h2331, 1, 19, 8'h20, 8'h01, 0);
        step("eor_zero",         0, 1, 16'h2733, 1, 19, 8'h00, 8'h03, 0);
        step("or",               0, 1, 16'h2B30, 1, 19, 8'hE1, 8'h15, 0);
        step("ldi_r20_80",       0, 1, 16'hE840, 1, 20, 8'h80, 8'h15, 0);
        step("add_overflow",     0, 1, 16'h0F44, 1, 20, 8'h00, 8'h1B, 0);
        step("dec_wrap",         0, 1, 16'h954A, 1, 20, 8'hFF, 8'h15, 0);
        step("nop",              0, 1, 16'h0000, 0, 20, 8'hFF, 8'h15, 0);
        step("ldi_r21",          0, 1, 16'hE555, 1, 21, 8'h55, 8'h15, 0);
        step("reset_midstream",  1, 1, 16'hEA6A, 0, 0, 8'h00, 8'h00, 0);
        step("rd_r21",           0, 1, 16'h2E05, 1, 0, 8'h00, 8'h00, 0);
        step("rd_r22",           0, 1, 16'h2E06, 1, 0, 8'h00, 8'h00, 0);
        step("rd_r16",           0, 1, 16'h2E00, 1, 0, 8'h00, 8'h00, 0);
        step("rd_r20",           0, 1, 16'h2E04, 1, 0, 8'h00, 8'h00, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
